vcache_line_fetch: RTL and testbench
====================================

// Module: vcache_line_fetch
// PURPOSE
//  Wishbone master m0 (video side) of the cellram arbiter; reads the framebuffer from cellram.
//  Streams the frame as 32-bit words into a first-word-fall-through FIFO.
//  The VGA pixel serializer drains the FIFO. Fetching restarts at FB_BASE on every frame_start.
// PARAMETERS
//  FB_BASE     32'h0040_0000  byte address of word 0 of the frame
//  FRAME_WORDS 38400          words per frame (640x480 @ 4bpp)
//  FIFO_AW     5              FIFO address width; depth = 2**FIFO_AW = 32
// PORTS
//  wb_clk       in   1        single clock, 50 MHz
//  wb_rst_n     in   1        synchronous reset, active low
//  enable       in   1        1 = fetching allowed
//  frame_start  in   1        one-cycle pulse at vsync: restart frame
//  wb_gnt       in   1        arbiter grant to this master
//  wb_adr_o     out  32       read address
//  wb_dat_o     out  32       constant 0
//  wb_sel_o     out  4        constant 4'hF
//  wb_cyc_o     out  1        bus cycle
//  wb_stb_o     out  1        strobe
//  wb_we_o      out  1        constant 0
//  wb_dat_i     in   32       read data
//  wb_ack_i     in   1        transfer ack
//  pix_rd       in   1        pop head word
//  pix_data     out  32       FIFO head, valid when pix_valid=1
//  pix_valid    out  1        FIFO not empty
//  fifo_level   out  FIFO_AW+1 occupancy, 0..2**FIFO_AW
//  frame_done   out  1        all FRAME_WORDS fetched this frame
//  underflow    out  1        sticky: pix_rd seen while empty
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-low.
//  - Reset (wb_rst_n=0 at edge): state IDLE, all outputs 0, wb_sel_o=4'hF, addr=FB_BASE, word_cnt=0.
//  - Reset mid-transaction drops cyc/stb in the same edge and empties the FIFO.
//  - Bus protocol: Wishbone classic single read.
//    - cyc=stb=1 and adr are held stable until an accepted ack; at most one transfer outstanding.
//    - Accepted ack = wb_ack_i & wb_gnt & cyc. An ack without gnt is ignored.
//    - cyc/stb drop in the cycle after the accepted ack; a new request starts no earlier than one cycle later.
//  - FSM states: IDLE, FETCH, HOLD, FLUSH, DONE.
//    - IDLE: wait for frame_start & enable -> FETCH. Load addr=FB_BASE and word_cnt=0.
//    - FETCH: drive request. On accepted ack: push wb_dat_i, addr+=4, word_cnt+=1.
//      - word_cnt reaches FRAME_WORDS -> DONE.
//      - Otherwise, if level after push == depth -> HOLD.
//      - Otherwise stay in FETCH (new request after the idle cycle).
//    - HOLD: cyc=0. Level < depth -> FETCH.
//    - DONE: cyc=0, frame_done=1. frame_start -> restart as in IDLE. frame_done clears.
//    - enable=0: finish any open transfer, then -> IDLE.
//  - frame_start while a transfer is open (FETCH, cyc=1) -> FLUSH.
//    - FLUSH keeps the request until the accepted ack and discards that data.
//    - FLUSH then reloads FB_BASE and goes to FETCH.
//  - frame_start with no transfer open: FIFO emptied the same edge; addr=FB_BASE, word_cnt=0; -> FETCH.
//  - frame_start always empties the FIFO and clears underflow and frame_done.
//  - FIFO (FWFT): pix_data = head word combinationally; a push is visible on pix_data the next cycle when empty.
//    - Push and pop in the same cycle: level unchanged.
//    - Pop when empty: ignored, underflow<=1.
//    - Push is never attempted when full (guaranteed by HOLD).
//    - Pointers wrap modulo 2**FIFO_AW.
//  - Address arithmetic: 32-bit, +4 per word, no wrap inside a frame.
//    - wb_adr_o[1:0] always 2'b00.
// TESTING
//  1. Reset, frame_start, ack 2 cycles after each stb with gnt=1, FRAME_WORDS=40.
//     -> 40 reads at FB_BASE..FB_BASE+0x9C, in-order data, frame_done=1, cyc=0.
//  2. No pix_rd.
//     -> level climbs to 32, HOLD with cyc=0. One pix_rd -> exactly one new read; level back to 32.
//  3. gnt=0 with ack pulses for 10 cycles, then gnt=1.
//     -> no push, adr stable during gnt=0; first accepted ack pushes word 0.
//  4. frame_start while cyc=1 at word 7.
//     -> that ack's data dropped, FIFO level 0, next adr=FB_BASE, underflow cleared.
//  5. pix_rd at level 0.
//     -> underflow=1 and stays 1. Simultaneous push+pop at level 5 -> level stays 5.
//  6. wb_rst_n=0 mid-read.
//     -> next cycle cyc=stb=0, pix_valid=0, level 0, frame_done=0, underflow=0.

Source files
------------

// File: rtl/vcache_line_fetch.sv
// Video-side Wishbone read master: streams the framebuffer from cellram
// into a small first-word-fall-through FIFO drained by the pixel serializer.
module vcache_line_fetch #(
  parameter logic [31:0] FB_BASE     = 32'h0040_0000,
  parameter int          FRAME_WORDS = 38400,
  parameter int          FIFO_AW     = 5
) (
  input  logic               wb_clk,
  input  logic               wb_rst_n,
  input  logic               enable,
  input  logic               frame_start,
  input  logic               wb_gnt,
  output logic [31:0]        wb_adr_o,
  output logic [31:0]        wb_dat_o,
  output logic [3:0]         wb_sel_o,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  input  logic [31:0]        wb_dat_i,
  input  logic               wb_ack_i,
  input  logic               pix_rd,
  output logic [31:0]        pix_data,
  output logic               pix_valid,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               frame_done,
  output logic               underflow
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  localparam logic [FIFO_AW:0] LVL_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_WORDS - 1);
  localparam logic [29:0]      WADR_BASE = FB_BASE[31:2];

  typedef enum logic [2:0] {IDLE, FETCH, HOLD, FLUSH, DONE} state_t;

  state_t             state_q, state_d;
  logic               cyc_q, cyc_d;
  logic [29:0]        wadr_q, wadr_d;     // word address; byte lanes always 00
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               unf_q, unf_d;
  logic [31:0]        mem [DEPTH];

  logic               ack_acc;
  logic               push;
  logic               pop;
  logic               flush_fifo;
  logic [FIFO_AW:0]   level_push;

  assign ack_acc    = wb_ack_i & wb_gnt & cyc_q;
  assign pop        = pix_rd & (level_q != '0);
  // occupancy as it will be after a push this cycle, including a concurrent pop
  assign level_push = level_q + LVL_ONE - (pop ? LVL_ONE : '0);

  assign wb_adr_o   = {wadr_q, 2'b00};
  assign wb_dat_o   = '0;
  assign wb_sel_o   = 4'hF;
  assign wb_we_o    = 1'b0;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign pix_valid  = (level_q != '0);
  assign pix_data   = pix_valid ? mem[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign frame_done = (state_q == DONE);
  assign underflow  = unf_q;

  // Fetch FSM next-state: frame_start overrides everything; an open transfer must be flushed first
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    wadr_d     = wadr_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    flush_fifo = 1'b0;
    if (frame_start) begin
      flush_fifo = 1'b1;
      if (cyc_q && !ack_acc) begin
        state_d = FLUSH;
      end else begin
        cyc_d   = 1'b0;
        wadr_d  = WADR_BASE;
        cnt_d   = '0;
        state_d = enable ? FETCH : IDLE;
      end
    end else begin
      case (state_q)
        IDLE: cyc_d = 1'b0;
        FETCH: begin
          if (cyc_q) begin
            if (ack_acc) begin
              push   = 1'b1;
              cyc_d  = 1'b0;
              wadr_d = wadr_q + 30'd1;
              cnt_d  = cnt_q + CNT_W'(1);
              if (cnt_q == CNT_LAST)        state_d = DONE;
              else if (!enable)             state_d = IDLE;
              else if (level_push == LVL_FULL) state_d = HOLD;
            end
          end else if (!enable) begin
            state_d = IDLE;
          end else begin
            cyc_d = 1'b1;
          end
        end
        HOLD: begin
          cyc_d = 1'b0;
          if (!enable)                  state_d = IDLE;
          else if (level_q < LVL_FULL)  state_d = FETCH;
        end
        FLUSH: begin
          if (ack_acc) begin
            cyc_d   = 1'b0;
            wadr_d  = WADR_BASE;
            cnt_d   = '0;
            state_d = enable ? FETCH : IDLE;
          end
        end
        DONE: cyc_d = 1'b0;
        default: begin
          state_d = IDLE;
          cyc_d   = 1'b0;
        end
      endcase
    end
  end

  // FIFO pointer/occupancy next-state and sticky underflow flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    unf_d    = unf_q;
    if (flush_fifo) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      unf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      level_d = level_q + (push ? LVL_ONE : '0) - (pop ? LVL_ONE : '0);
      if (pix_rd && (level_q == '0)) unf_d = 1'b1;
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q  <= IDLE;
      cyc_q    <= 1'b0;
      wadr_q   <= WADR_BASE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      wadr_q   <= wadr_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      unf_q    <= unf_d;
    end
  end

  // FIFO storage: data only, no reset needed
  always_ff @(posedge wb_clk) begin
    if (push) mem[wr_ptr_q] <= wb_dat_i;
  end

endmodule

// File: tb/tb_vcache_line_fetch.sv
// Directed bench for vcache_line_fetch with a small frame (40 words).
module tb_vcache_line_fetch;

  localparam logic [31:0] FB_BASE = 32'h0040_0000;
  localparam int          FW      = 40;
  localparam int          AW      = 5;

  logic          wb_clk;
  logic          wb_rst_n;
  logic          enable;
  logic          frame_start;
  logic          wb_gnt;
  logic [31:0]   wb_adr_o;
  logic [31:0]   wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [31:0]   wb_dat_i;
  logic          wb_ack_i;
  logic          pix_rd;
  logic [31:0]   pix_data;
  logic          pix_valid;
  logic [AW:0]   fifo_level;
  logic          frame_done;
  logic          underflow;

  vcache_line_fetch #(.FB_BASE(FB_BASE), .FRAME_WORDS(FW), .FIFO_AW(AW)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .enable(enable), .frame_start(frame_start),
    .wb_gnt(wb_gnt), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .pix_rd(pix_rd), .pix_data(pix_data), .pix_valid(pix_valid),
    .fifo_level(fifo_level), .frame_done(frame_done), .underflow(underflow)
  );

  initial begin
    wb_clk = 1'b0;
    forever #5 wb_clk = ~wb_clk;
  end

  int checks = 0;
  int errors = 0;

  // responder / tracking state
  bit auto_ack = 1'b1;
  bit ack_drv  = 1'b0;
  int wcnt     = 0;
  bit prev_cyc = 1'b0;
  bit cyc_rose = 1'b0;
  int req_cnt  = 0;
  bit adr_chk  = 1'b0;
  bit drain    = 1'b0;
  bit drain_chk = 1'b0;
  int rd_idx   = 0;

  function automatic logic [31:0] mk(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: sample 1 time unit after the edge, then update slave and drain
  task automatic tick();
    @(posedge wb_clk);
    #1;
    cyc_rose = wb_cyc_o && !prev_cyc;
    prev_cyc = wb_cyc_o;
    if (cyc_rose) begin
      if (adr_chk) chk("req_adr", wb_adr_o, FB_BASE + 32'(req_cnt) * 4);
      req_cnt++;
    end
    if (auto_ack) begin
      if (ack_drv) begin
        ack_drv = 1'b0;
        wcnt    = 0;
      end else if (wb_cyc_o) begin
        wcnt++;
        if (wcnt >= 2) ack_drv = 1'b1;
      end else begin
        wcnt = 0;
      end
      wb_ack_i = ack_drv;
      wb_dat_i = mk(wb_adr_o);
    end
    if (drain && pix_valid) begin
      if (drain_chk) chk("pix_order", pix_data, mk(FB_BASE + 32'(rd_idx) * 4));
      rd_idx++;
      pix_rd = 1'b1;
    end else begin
      pix_rd = 1'b0;
    end
  endtask

  initial begin
    bit got;
    int bad;
    int snap;
    wb_rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; wb_gnt = 1'b1;
    wb_ack_i = 1'b0; wb_dat_i = '0; pix_rd = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_cyc", 32'(wb_cyc_o), 0);
    chk("rst_stb", 32'(wb_stb_o), 0);
    chk("rst_sel", 32'(wb_sel_o), 32'hF);
    chk("rst_we", 32'(wb_we_o), 0);
    chk("rst_dat_o", wb_dat_o, 0);
    chk("rst_adr", wb_adr_o, FB_BASE);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_unf", 32'(underflow), 0);

    // 1: full frame with continuous drain
    wb_rst_n = 1'b1; enable = 1'b1;
    adr_chk = 1'b1; drain = 1'b1; drain_chk = 1'b1; req_cnt = 0; rd_idx = 0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (frame_done) begin got = 1'b1; break; end
    end
    chk("t1_done_wait", 32'(got), 1);
    for (int i = 0; i < 10; i++) tick();
    chk("t1_reqs", 32'(req_cnt), FW);
    chk("t1_words_read", 32'(rd_idx), FW);
    chk("t1_done", 32'(frame_done), 1);
    chk("t1_cyc", 32'(wb_cyc_o), 0);
    chk("t1_level", 32'(fifo_level), 0);
    chk("t1_unf", 32'(underflow), 0);
    adr_chk = 1'b0; drain = 1'b0; drain_chk = 1'b0;

    // 2: no drain, FIFO fills and holds
    req_cnt = 0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("t2_done_clr", 32'(frame_done), 0);
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (fifo_level == 6'd32) begin got = 1'b1; break; end
    end
    chk("t2_fill_wait", 32'(got), 1);
    for (int i = 0; i < 5; i++) tick();
    chk("t2_hold_cyc", 32'(wb_cyc_o), 0);
    chk("t2_hold_level", 32'(fifo_level), 32);
    chk("t2_reqs", 32'(req_cnt), 32);
    chk("t2_head", pix_data, mk(FB_BASE));
    pix_rd = 1'b1; tick();
    for (int i = 0; i < 15; i++) tick();
    chk("t2_one_more_req", 32'(req_cnt), 33);
    chk("t2_level_back", 32'(fifo_level), 32);
    chk("t2_cyc_after", 32'(wb_cyc_o), 0);
    chk("t2_head_after", pix_data, mk(FB_BASE + 4));

    // 3: acks without grant are ignored
    auto_ack = 1'b0; wb_gnt = 1'b0; wb_ack_i = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick();
    chk("t3_cyc_up", 32'(wb_cyc_o), 1);
    chk("t3_adr", wb_adr_o, FB_BASE);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      wb_ack_i = (i % 2 == 0);
      wb_dat_i = mk(wb_adr_o);
      tick();
      if (wb_adr_o !== FB_BASE || fifo_level !== '0 || wb_cyc_o !== 1'b1) bad++;
    end
    chk("t3_stable_no_push", 32'(bad), 0);
    wb_gnt = 1'b1; wb_ack_i = 1'b1; wb_dat_i = mk(wb_adr_o);
    tick();
    wb_ack_i = 1'b0;
    chk("t3_level", 32'(fifo_level), 1);
    chk("t3_word0", pix_data, mk(FB_BASE));
    chk("t3_cyc_drop", 32'(wb_cyc_o), 0);

    // 4: frame_start during an open transfer at word 7
    auto_ack = 1'b1; ack_drv = 1'b0; wcnt = 0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    pix_rd = 1'b1; tick();
    chk("t4_unf_set", 32'(underflow), 1);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (cyc_rose && wb_adr_o == FB_BASE + 28) begin got = 1'b1; break; end
    end
    chk("t4_word7_wait", 32'(got), 1);
    chk("t4_level7", 32'(fifo_level), 7);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("t4_flush_cyc", 32'(wb_cyc_o), 1);
    chk("t4_flush_adr", wb_adr_o, FB_BASE + 28);
    chk("t4_flush_level", 32'(fifo_level), 0);
    chk("t4_unf_clr", 32'(underflow), 0);
    tick();
    chk("t4_drop_level", 32'(fifo_level), 0);
    chk("t4_drop_cyc", 32'(wb_cyc_o), 0);
    chk("t4_reload_adr", wb_adr_o, FB_BASE);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cyc_rose) begin got = 1'b1; break; end
    end
    chk("t4_rereq_wait", 32'(got), 1);
    chk("t4_rereq_adr", wb_adr_o, FB_BASE);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fifo_level == 6'd1) begin got = 1'b1; break; end
    end
    chk("t4_push_wait", 32'(got), 1);
    chk("t4_first_word", pix_data, mk(FB_BASE));

    // 5: simultaneous push+pop, then underflow stickiness
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fifo_level == 6'd5 && wb_ack_i) begin got = 1'b1; break; end
    end
    chk("t5_l5_wait", 32'(got), 1);
    pix_rd = 1'b1; tick();
    chk("t5_pushpop_level", 32'(fifo_level), 5);
    chk("t5_pushpop_head", pix_data, mk(FB_BASE + 4));
    enable = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    snap = req_cnt;
    drain = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fifo_level == '0) begin got = 1'b1; break; end
    end
    chk("t5_drain_wait", 32'(got), 1);
    drain = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t5_idle_no_req", 32'(req_cnt), 32'(snap));
    chk("t5_idle_cyc", 32'(wb_cyc_o), 0);
    chk("t5_no_unf_yet", 32'(underflow), 0);
    pix_rd = 1'b1; tick();
    chk("t5_unf_set", 32'(underflow), 1);
    for (int i = 0; i < 5; i++) tick();
    chk("t5_unf_sticky", 32'(underflow), 1);
    chk("t5_level0", 32'(fifo_level), 0);

    // 6: reset in the middle of a read
    enable = 1'b1;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    pix_rd = 1'b1; tick();
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fifo_level >= 6'd2 && wb_cyc_o) begin got = 1'b1; break; end
    end
    chk("t6_busy_wait", 32'(got), 1);
    chk("t6_unf_pre", 32'(underflow), 1);
    wb_rst_n = 1'b0; tick();
    chk("t6_cyc", 32'(wb_cyc_o), 0);
    chk("t6_stb", 32'(wb_stb_o), 0);
    chk("t6_valid", 32'(pix_valid), 0);
    chk("t6_level", 32'(fifo_level), 0);
    chk("t6_done", 32'(frame_done), 0);
    chk("t6_unf", 32'(underflow), 0);
    chk("t6_adr", wb_adr_o, FB_BASE);
    wb_rst_n = 1'b1; ack_drv = 1'b0; wcnt = 0; wb_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_idle_cyc", 32'(wb_cyc_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
